// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_pkg                                               |
// | Description : Shared constants, mode enum and sizing helper for the  |
// |               parametrised synchronous FIFO.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fifo_pkg;

   localparam int FIFO_DEF_WIDTH = 8;
   localparam int FIFO_DEF_DEPTH = 64;

   // Read-path flavour: registered read or first-word-fall-through
   typedef enum logic {
      STD  = 1'b0,
      FWFT = 1'b1
   } fifo_mode_e;

   // Occupancy counter must represent 0..DEPTH inclusive
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_mem                                               |
// | Description : WIDTH x DEPTH register array, one synchronous write    |
// |               port and one asynchronous read port. Not reset.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_DEF_WIDTH,
   parameter int DEPTH = FIFO_DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port: storage has no reset so it maps onto plain flops/LUT-RAM
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo_param                                        |
// | Description : Parametrised single-clock FIFO with almost-full/empty, |
// |               sticky overflow/underflow, synchronous flush and a     |
// |               selectable registered or FWFT read path.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH     = FIFO_DEF_WIDTH,
   parameter int DEPTH     = FIFO_DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4,
   parameter int FWFT      = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          wr_en,
   input  logic [WIDTH-1:0]              data_in,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [WIDTH-1:0]              data_out,
   output logic                          rd_valid,
   output logic [fifo_cnt_w(DEPTH)-1:0]  fifo_counter,
   output logic                          buf_empty,
   output logic                          buf_full,
   output logic                          almost_empty,
   output logic                          almost_full,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = fifo_cnt_w(DEPTH);

   localparam logic [CNT_W-1:0] c_full_lvl = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_af_lvl   = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] c_ae_lvl   = CNT_W'(AE_THRESH);

   // The enum member FWFT is reached through the package scope because the
   // module parameter of the same name shadows the wildcard import.
   localparam fifo_mode_e c_mode = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              ovf_q,    ovf_d;
   logic              udf_q,    udf_d;

   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [WIDTH-1:0]  w_rdata;

   // Status decodes come only from the registered occupancy count
   assign buf_empty    = (cnt_q == '0);
   assign buf_full     = (cnt_q == c_full_lvl);
   assign almost_empty = (cnt_q <= c_ae_lvl);
   assign almost_full  = (cnt_q >= c_af_lvl);
   assign fifo_counter = cnt_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   // Accepts use start-of-cycle status; flush suppresses both operations
   assign w_wr_acc = wr_en & ~buf_full  & ~flush;
   assign w_rd_acc = rd_en & ~buf_empty & ~flush;

   // Next-state for pointers, occupancy and sticky error flags
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;

      if (flush) begin
         // Contents discarded; error flags deliberately left as they were
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({w_wr_acc, w_rd_acc})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase

         // Clear first so a coincident new error keeps the flag set
         if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
         end
         if (wr_en && buf_full) begin
            ovf_d = 1'b1;
         end
         if (rd_en && buf_empty) begin
            udf_d = 1'b1;
         end
      end
   end

   // Control-state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (w_wr_acc),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (w_rdata)
   );

   generate
      if (c_mode == fifo_pkg::STD) begin : g_std_read
         logic [WIDTH-1:0] dout_q, dout_d;
         logic             vld_q,  vld_d;

         // Registered read: capture the head word on each accepted read
         always_comb begin
            dout_d = dout_q;
            vld_d  = 1'b0;
            if (w_rd_acc) begin
               dout_d = w_rdata;
               vld_d  = 1'b1;
            end
         end

         // Output register; data_out holds across idle cycles and flush
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               dout_q <= '0;
               vld_q  <= 1'b0;
            end else begin
               dout_q <= dout_d;
               vld_q  <= vld_d;
            end
         end

         assign data_out = dout_q;
         assign rd_valid = vld_q;
      end else begin : g_fwft_read
         // Head word is always presented; rd_en merely pops it
         assign data_out = w_rdata;
         assign rd_valid = ~buf_empty;
      end
   endgenerate

endmodule : sync_fifo_param
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sync_fifo_param                                     |
// | Description : Directed self-checking bench; a registered-read and a  |
// |               FWFT instance share one stimulus stream.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sync_fifo_param;

   localparam int W  = 8;
   localparam int D  = 8;
   localparam int CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush, wr_en, rd_en, clr_err;
   logic [W-1:0]  data_in;

   logic [W-1:0]  data_out,  f_data_out;
   logic          rd_valid,  f_rd_valid;
   logic [CW-1:0] cnt,       f_cnt;
   logic          empty,     f_empty;
   logic          full,      f_full;
   logic          ae,        f_ae;
   logic          af,        f_af;
   logic          ovf,       f_ovf;
   logic          udf,       f_udf;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(
      .WIDTH(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)
   ) u_std (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .clr_err(clr_err), .data_out(data_out), .rd_valid(rd_valid),
      .fifo_counter(cnt), .buf_empty(empty), .buf_full(full),
      .almost_empty(ae), .almost_full(af), .overflow(ovf), .underflow(udf)
   );

   sync_fifo_param #(
      .WIDTH(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)
   ) u_fwft (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .clr_err(clr_err), .data_out(f_data_out), .rd_valid(f_rd_valid),
      .fifo_counter(f_cnt), .buf_empty(f_empty), .buf_full(f_full),
      .almost_empty(f_ae), .almost_full(f_af), .overflow(f_ovf), .underflow(f_udf)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; wr_en = 0; rd_en = 0; clr_err = 0; data_in = '0;
   endtask

   initial begin
      int exp_q[$];
      int e;

      idle();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();

      // Reset state
      chk("rst_cnt",   int'(cnt), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full",  int'(full), 0);
      chk("rst_ae",    int'(ae), 1);
      chk("rst_af",    int'(af), 0);
      chk("rst_ovf",   int'(ovf), 0);
      chk("rst_udf",   int'(udf), 0);
      chk("rst_vld",   int'(rd_valid), 0);
      chk("rst_dout",  int'(data_out), 0);
      chk("rst_f_full", int'(f_full), 0);
      chk("rst_f_ae",  int'(f_ae), 1);
      chk("rst_f_af",  int'(f_af), 0);
      chk("rst_f_ovf", int'(f_ovf), 0);
      chk("rst_f_udf", int'(f_udf), 0);

      // Fill with 0x11..0x88
      for (int i = 0; i < 8; i++) begin
         wr_en = 1; data_in = W'((i + 1) * 'h11);
         step();
         chk("fill_cnt", int'(cnt), i + 1);
         chk("fill_af",  int'(af), (i + 1 >= 6) ? 1 : 0);
      end
      chk("fill_full", int'(full), 1);
      chk("fill_ovf0", int'(ovf), 0);
      data_in = 8'h99;
      step();
      wr_en = 0;
      chk("ovf_set", int'(ovf), 1);
      chk("ovf_cnt", int'(cnt), 8);

      // Drain in order
      for (int i = 0; i < 8; i++) begin
         rd_en = 1;
         step();
         chk("drain_vld",  int'(rd_valid), 1);
         chk("drain_data", int'(data_out), (i + 1) * 'h11);
         chk("drain_ae",   int'(ae), (7 - i <= 1) ? 1 : 0);
      end
      chk("drain_empty", int'(empty), 1);
      step();
      rd_en = 0;
      chk("udf_set",  int'(udf), 1);
      chk("udf_vld",  int'(rd_valid), 0);
      chk("udf_hold", int'(data_out), 'h88);
      step();
      chk("idle_vld", int'(rd_valid), 0);
      clr_err = 1;
      step();
      clr_err = 0;
      chk("clr_ovf", int'(ovf), 0);
      chk("clr_udf", int'(udf), 0);

      // Hold occupancy at 4 with simultaneous read/write across wraps
      for (int i = 0; i < 4; i++) begin
         wr_en = 1; data_in = W'('h40 + i);
         exp_q.push_back('h40 + i);
         step();
      end
      chk("hold_pre", int'(cnt), 4);
      for (int k = 0; k < 20; k++) begin
         wr_en = 1; rd_en = 1; data_in = W'('h50 + k);
         e = exp_q.pop_front();
         exp_q.push_back('h50 + k);
         step();
         chk("rw_data", int'(data_out), e);
         chk("rw_cnt",  int'(cnt), 4);
      end
      wr_en = 0;
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         step();
         chk("rw_tail", int'(data_out), e);
      end
      rd_en = 0;
      step();
      chk("rw_empty", int'(empty), 1);
      chk("rw_udf",   int'(udf), 0);

      // Write and read together on an empty FIFO
      wr_en = 1; rd_en = 1; data_in = 8'hA5;
      step();
      idle();
      chk("we_cnt", int'(cnt), 1);
      chk("we_udf", int'(udf), 1);
      chk("we_vld", int'(rd_valid), 0);
      rd_en = 1;
      step();
      chk("we_data", int'(data_out), 'hA5);
      // Clear coinciding with a fresh underflow: the error wins
      clr_err = 1;
      step();
      idle();
      chk("clr_race", int'(udf), 1);
      clr_err = 1;
      step();
      clr_err = 0;
      chk("clr_udf2", int'(udf), 0);

      // Flush from count 5 with a write pending
      for (int i = 0; i < 5; i++) begin
         wr_en = 1; data_in = W'(i + 1);
         step();
      end
      chk("pre_flush", int'(cnt), 5);
      flush = 1; wr_en = 1; data_in = 8'hEE;
      step();
      idle();
      chk("fl_cnt",   int'(cnt), 0);
      chk("fl_empty", int'(empty), 1);
      chk("fl_ovf",   int'(ovf), 0);
      chk("fl_udf",   int'(udf), 0);
      chk("fl_hold",  int'(data_out), 'hA5);

      // Flush while full with a write: no overflow either
      for (int i = 0; i < 8; i++) begin
         wr_en = 1; data_in = W'('hC0 + i);
         step();
      end
      flush = 1; wr_en = 1; rd_en = 1;
      step();
      idle();
      chk("flf_cnt", int'(cnt), 0);
      chk("flf_ovf", int'(ovf), 0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) begin
         wr_en = 1; data_in = W'('h71 + i);
         step();
      end
      wr_en = 0; rd_en = 1;
      step();
      rd_en = 0;
      chk("pre_rst_vld",  int'(rd_valid), 1);
      chk("pre_rst_data", int'(data_out), 'h71);
      rst = 1'b0;
      #1;
      chk("arst_cnt",   int'(cnt), 0);
      chk("arst_vld",   int'(rd_valid), 0);
      chk("arst_dout",  int'(data_out), 0);
      chk("arst_empty", int'(empty), 1);
      chk("arst_f_cnt", int'(f_cnt), 0);
      step();
      rst = 1'b1;
      step();

      // FWFT instance: word falls through with no rd_en
      chk("f_empty0", int'(f_empty), 1);
      wr_en = 1; data_in = 8'h3C;
      step();
      wr_en = 0;
      chk("f_vld",  int'(f_rd_valid), 1);
      chk("f_data", int'(f_data_out), 'h3C);
      wr_en = 1; data_in = 8'h5A;
      step();
      wr_en = 0;
      chk("f_head", int'(f_data_out), 'h3C);
      chk("f_cnt2", int'(f_cnt), 2);
      rd_en = 1;
      step();
      rd_en = 0;
      chk("f_pop1", int'(f_data_out), 'h5A);
      chk("f_vld1", int'(f_rd_valid), 1);
      rd_en = 1;
      step();
      rd_en = 0;
      chk("f_empty", int'(f_empty), 1);
      chk("f_vld0",  int'(f_rd_valid), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule : tb_sync_fifo_param
`default_nettype wire
